// File: rtl/paper_ctrl_pkg.sv
// Shared constants for the paper_ctrl sequencer: opcodes, FSM states, sizes.
package paper_ctrl_pkg;

  localparam int         PC_W       = 4;
  localparam logic [7:0] ICOUNT_MAX = 8'd255;

  // Opcode field of a program word, bits [7:6].
  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_DEC  = 2'b01,
    OP_JNO  = 2'b10,
    OP_HALT = 2'b11
  } op_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

endpackage

// File: rtl/paper_pc.sv
// Program counter: 4-bit register with clear, load and wrapping increment.
module paper_pc
  import paper_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic            inc_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Next pc: clear wins over load, load wins over increment; 15+1 wraps to 0.
  always_comb begin
    pc_d = pc_q;
    if (clr_i) begin
      pc_d = '0;
    end else if (load_i) begin
      pc_d = target_i;
    end else if (inc_i) begin
      pc_d = pc_q + 1'b1;
    end
  end

  // pc register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/paper_ctrl.sv
// Tiny program sequencer: fetches 8-bit words, drives INC/DEC/JNO/HALT to a
// datapath, counts retired instructions and stops on an instruction budget.
// Handshake: none; start is a one-cycle pulse honoured only in IDLE or HALT,
// and imem_data is expected one cycle after imem_addr.
module paper_ctrl
  import paper_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [3:0] imem_addr,
  input  logic [7:0] imem_data,
  input  logic       zero,
  output logic [1:0] instruct,
  output logic       enabled,
  output logic [1:0] reg_sel,
  output logic       reg_we,
  output logic       busy,
  output logic       halted,
  output logic       timeout,
  output logic [7:0] icount,
  output logic [2:0] state_dbg
);

  state_e          state_q, state_d;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      icount_q, icount_d;
  logic            timeout_q, timeout_d;
  logic            pc_clr, pc_load, pc_inc;
  logic [PC_W-1:0] pc;
  op_e             op;
  logic            budget_out;

  assign op = op_e'(ir_q[7:6]);
  // Budget is spent once 255 instructions have retired; the next non-HALT
  // instruction is not performed and the block stops with timeout set.
  assign budget_out = (icount_q == ICOUNT_MAX) && (op != OP_HALT);

  paper_pc u_pc (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (pc_clr),
    .load_i   (pc_load),
    .inc_i    (pc_inc),
    .target_i (ir_q[3:0]),
    .pc_o     (pc)
  );

  // Next-state, pc control and datapath strobes.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    icount_d  = icount_q;
    timeout_d = timeout_q;
    pc_clr    = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    instruct  = OP_INC;
    reg_we    = 1'b0;
    enabled   = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_clr    = 1'b1;
          icount_d  = '0;
          timeout_d = 1'b0;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        ir_d    = imem_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        instruct = op;
        if (budget_out) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else begin
          icount_d = (icount_q == ICOUNT_MAX) ? icount_q : icount_q + 8'd1;
          case (op)
            OP_INC, OP_DEC: begin
              // Gated by reset_n so a reset landing in EXEC issues no write.
              reg_we  = reset_n;
              pc_inc  = 1'b1;
              state_d = S_FETCH;
            end
            OP_JNO: begin
              state_d = S_FETCH;
              if (zero) begin
                pc_inc  = 1'b1;
                enabled = reset_n;
              end else begin
                pc_load = 1'b1;
              end
            end
            default: state_d = S_HALT;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, instruction register, icount and sticky timeout.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      icount_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      icount_q  <= icount_d;
      timeout_q <= timeout_d;
    end
  end

  assign imem_addr = pc;
  assign reg_sel   = ir_q[5:4];
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted    = (state_q == S_HALT);
  assign timeout   = timeout_q;
  assign icount    = icount_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_paper_ctrl.sv
// Bench for paper_ctrl: program memory and a 4-register datapath around the
// DUT, a program interpreter as reference, cycle-by-cycle checks.
module tb_paper_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] imem_addr;
  logic [7:0] imem_data;
  logic       zero;
  logic [1:0] instruct;
  logic       enabled;
  logic [1:0] reg_sel;
  logic       reg_we;
  logic       busy;
  logic       halted;
  logic       timeout;
  logic [7:0] icount;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  paper_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .zero      (zero),
    .instruct  (instruct),
    .enabled   (enabled),
    .reg_sel   (reg_sel),
    .reg_we    (reg_we),
    .busy      (busy),
    .halted    (halted),
    .timeout   (timeout),
    .icount    (icount),
    .state_dbg (state_dbg)
  );

  // ---------------- environment: memory and datapath ----------------
  logic [7:0] mem [16];
  logic [7:0] dp [4];
  logic [7:0] dp_init [4];
  logic       dp_load = 1'b0;

  always @(posedge clk) imem_data <= mem[imem_addr];

  always @(posedge clk) begin
    if (dp_load) begin
      for (int i = 0; i < 4; i++) dp[i] <= dp_init[i];
    end else if (reg_we) begin
      dp[reg_sel] <= (instruct == 2'b00) ? dp[reg_sel] + 8'd1 : dp[reg_sel] - 8'd1;
    end
  end

  assign zero = (dp[reg_sel] == 8'd0);

  // ---------------- scoreboard ----------------
  // One entry per executed instruction: {pc[3:0], op[1:0], rsel[1:0], we, en}
  logic [9:0] exp_q[$];
  int         exp_icount;
  int         exp_pc_final;
  bit         exp_timeout;
  int         exp_regs [4];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: interpret the program at instruction level.
  task automatic build_model();
    int pc, nxt, cnt, op, rs, tg;
    int r [4];
    bit we, en;
    logic [7:0] w;
    exp_q.delete();
    for (int i = 0; i < 4; i++) r[i] = int'(dp_init[i]);
    pc = 0;
    cnt = 0;
    exp_timeout = 1'b0;
    forever begin
      w  = mem[pc];
      op = int'(w[7:6]);
      rs = int'(w[5:4]);
      tg = int'(w[3:0]);
      we = 1'b0;
      en = 1'b0;
      nxt = pc;
      if (op != 3 && cnt == 255) begin
        exp_q.push_back({4'(pc), 2'(op), 2'(rs), 1'b0, 1'b0});
        exp_timeout = 1'b1;
        break;
      end
      cnt = (cnt < 255) ? cnt + 1 : 255;
      case (op)
        0: begin we = 1'b1; r[rs] = (r[rs] + 1) % 256;   nxt = (pc + 1) % 16; end
        1: begin we = 1'b1; r[rs] = (r[rs] + 255) % 256; nxt = (pc + 1) % 16; end
        2: begin
          if (r[rs] == 0) begin en = 1'b1; nxt = (pc + 1) % 16; end
          else nxt = tg;
        end
        default: nxt = pc;
      endcase
      exp_q.push_back({4'(pc), 2'(op), 2'(rs), we, en});
      if (op == 3) break;
      pc = nxt;
    end
    exp_icount   = cnt;
    exp_pc_final = pc;
    for (int i = 0; i < 4; i++) exp_regs[i] = r[i];
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_dp();
    dp_load = 1'b1;
    tick();
    dp_load = 1'b0;
  endtask

  task automatic fill_mem(input logic [7:0] w);
    for (int i = 0; i < 16; i++) mem[i] = w;
  endtask

  // Start the loaded program and follow it instruction by instruction.
  // With noisy set, start is also pulsed at random while the DUT is busy.
  task automatic run_prog(input bit noisy);
    logic [9:0] e;
    int k;
    build_model();
    load_dp();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_timeout", timeout, 0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("fetch_busy", busy, 1);
      chk("fetch_addr", imem_addr, e[9:6]);
      chk("fetch_icount", icount, (k < 255) ? k : 255);
      chk("fetch_strobes", {instruct, reg_we, enabled}, 0);
      if (noisy) start = ($urandom_range(0, 3) == 0);
      tick();
      chk("wait_strobes", {instruct, reg_we, enabled}, 0);
      if (noisy) start = ($urandom_range(0, 3) == 0);
      tick();
      chk("exec_instruct", instruct, e[5:4]);
      chk("exec_reg_sel", reg_sel, e[3:2]);
      chk("exec_reg_we", reg_we, e[1]);
      chk("exec_enabled", enabled, e[0]);
      if (noisy) start = ($urandom_range(0, 3) == 0);
      tick();
      start = 1'b0;
      k++;
    end
    chk("end_halted", halted, 1);
    chk("end_busy", busy, 0);
    chk("end_timeout", timeout, exp_timeout);
    chk("end_icount", icount, exp_icount);
    chk("end_pc", imem_addr, exp_pc_final);
    for (int i = 0; i < 4; i++) chk("end_dp_reg", dp[i], exp_regs[i]);
    // HALT holds everything
    tick();
    tick();
    chk("halt_hold", {halted, timeout, icount, imem_addr}, {1'b1, exp_timeout, 8'(exp_icount), 4'(exp_pc_final)});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {instruct, enabled, reg_we, reg_sel, busy, halted, timeout, icount, imem_addr}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    for (int i = 0; i < 4; i++) dp_init[i] = 8'd0;
    fill_mem(8'hC0);
    load_dp();
    tick();
    chk_reset_outputs("reset_state");
    reset_n = 1'b1;
    tick();
    chk_reset_outputs("idle_after_reset");

    // INC r1, INC r1, HALT
    fill_mem(8'hC0);
    mem[0] = 8'h10;
    mem[1] = 8'h10;
    run_prog(1'b0);

    // DEC r2; JNO r2 -> 0; HALT  with r2 = 3: loops twice, falls through once
    fill_mem(8'hC0);
    mem[0] = 8'h60;
    mem[1] = 8'hA0;
    dp_init[2] = 8'd3;
    run_prog(1'b0);

    // JNO r0 -> 0 with r0 nonzero: self-loop until timeout
    fill_mem(8'hC0);
    mem[0] = 8'h80;
    dp_init[0] = 8'd5;
    run_prog(1'b0);

    // sixteen INC r0, no HALT: pc wraps, ends on timeout
    fill_mem(8'h00);
    run_prog(1'b1);

    // reset during EXEC of an INC
    fill_mem(8'hC0);
    mem[0] = 8'h10;
    for (int i = 0; i < 4; i++) dp_init[i] = 8'd0;
    load_dp();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_reset_we", reg_we, 1);
    reset_n = 1'b0;
    #1;
    chk("reset_exec_we", reg_we, 0);
    tick();
    chk_reset_outputs("reset_mid_exec");
    chk("reset_dp_untouched", dp[1], 0);
    // reset together with start
    start = 1'b1;
    tick();
    chk_reset_outputs("reset_with_start");
    reset_n = 1'b1;
    start   = 1'b0;
    tick();
    chk_reset_outputs("idle_after_reset2");

    // random programs with random start noise while busy
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 4; i++) dp_init[i] = 8'($urandom_range(0, 3));
      run_prog(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case the run never reaches its summary.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
